// File: rtl/if_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package if_pkg;

  // REQ and DRAIN both have bit 0 set, so the fetch request is a single flop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DRAIN = 2'b11
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 21;
  localparam int OPC_WIDTH   = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, branch redirect and
// the valid/ready hand-off to decode. master is the fetch stage itself.
interface if_stage_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  import if_pkg::*;

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   id_valid;
  logic                   id_ready;
  logic [PC_WIDTH-1:0]    id_pc;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic [OPC_WIDTH-1:0]   id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Small circular buffer holding fetched {pc, instr} entries until decode
// takes them. Flush beats push and pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic                          i_flush,
  input  logic [WIDTH-1:0]              i_data,
  output logic [WIDTH-1:0]              o_head,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (i_push && !i_pop)      r_count <= r_count + CNT_ONE;
      else if (!i_push && i_pop) r_count <= r_count - CNT_ONE;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC register, instruction-memory req/ack
// sequencer, output buffer and branch-redirect handling.
//
//   state | meaning
//   IDLE  | no request outstanding; waits for buffer room or a redirect
//   REQ   | request outstanding at pc; ack pushes the word into the buffer
//   DRAIN | request outstanding at a stale pc after a redirect; its ack is
//         | thrown away and fetch restarts at pending_pc
module if_stage
  import if_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_WIDTH + INSTR_WIDTH;
  localparam logic [CW-1:0]       CNT_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(INSTR_BYTES);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nx;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_nx;
  logic [PC_WIDTH-1:0]   r_pending_pc;
  logic [PC_WIDTH-1:0]   w_pending_nx;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_id_valid;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_cnt_nx;
  logic [EW-1:0]         w_head;
  logic [INSTR_WIDTH-1:0] w_id_instr;

  // A redirect in the same cycle as id_ready is a flush, never a consume.
  assign w_pop      = w_id_valid & bus.id_ready & ~bus.redirect;
  assign w_push     = (r_state == REQ) & bus.imem_ack & ~bus.redirect;
  assign w_flush    = bus.redirect;
  assign w_id_valid = (w_count != '0);
  assign w_cnt_nx   = w_count - CW'(w_pop) + CW'(w_push);

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({r_pc, bus.imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // State, fetch PC and the parked redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_pending_pc <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_pending_pc <= w_pending_nx;
    end
  end

  // Next-state and PC selection. pc never moves while a request is
  // outstanding unless that request is being acked this cycle.
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_pending_nx = r_pending_pc;
    case (r_state)
      IDLE: begin
        if (bus.redirect) begin
          w_pc_nx    = bus.redirect_pc;
          w_state_nx = REQ;
        end else if (w_cnt_nx < CNT_DEPTH) begin
          w_state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            w_pc_nx = bus.redirect_pc;
          end else begin
            w_pc_nx = r_pc + PC_INC;
            if (w_cnt_nx >= CNT_DEPTH) w_state_nx = IDLE;
          end
        end else if (bus.redirect) begin
          w_pending_nx = bus.redirect_pc;
          w_state_nx   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.redirect) w_pending_nx = bus.redirect_pc;
        if (bus.imem_ack) begin
          w_pc_nx    = bus.redirect ? bus.redirect_pc : r_pending_pc;
          w_state_nx = REQ;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Request is bit 0 of the state register, address is the PC flop.
  assign bus.imem_req  = r_state[0];
  assign bus.imem_addr = r_pc;

  // Head fields read as zero whenever nothing is buffered.
  assign w_id_instr    = w_id_valid ? w_head[INSTR_WIDTH-1:0] : '0;
  assign bus.id_valid  = w_id_valid;
  assign bus.id_pc     = w_id_valid ? w_head[EW-1:INSTR_WIDTH] : '0;
  assign bus.id_instr  = w_id_instr;
  assign bus.id_opcode = w_id_instr[OPC_MSB:OPC_LSB];

endmodule
